// File: rtl/logic_unit_acc.sv
// Registered WIDTH-bit logic unit with valid/ready handshake and a multi-beat reduce mode.
// Optional o_par output (registered parity of o) is enabled by defining LOGIC_PARITY_EN.
module logic_unit_acc #(
  parameter int WIDTH   = 8,
  parameter int BEATS_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic               reduce,
  input  logic [BEATS_W-1:0] len,
  input  logic [WIDTH-1:0]   i0,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   o
`ifdef LOGIC_PARITY_EN
  ,
  output logic               o_par
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_o;
  logic [WIDTH-1:0]   r_acc;
  logic [BEATS_W-1:0] r_cnt;
  logic [BEATS_W-1:0] r_len;
  logic [2:0]         r_op;

  logic               w_accept;
  logic               w_load;
  logic [WIDTH-1:0]   w_o_nxt;
  logic               w_acc_load;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [BEATS_W-1:0] w_cnt_nxt;
  logic               w_latch;
  logic [WIDTH-1:0]   w_fold;

  // base op selected by op mod 3: AND, OR, XOR
  function automatic logic [WIDTH-1:0] base_f(input logic [2:0] f_op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (f_op)
      3'd0, 3'd3: res = a & b;
      3'd1, 3'd4: res = a | b;
      default:    res = a ^ b;
    endcase
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] logic_f(input logic [2:0] f_op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] res;
    case (f_op)
      3'd6:    res = ~a;
      3'd7:    res = (s & b) | (~s & a);
      3'd3,
      3'd4,
      3'd5:    res = ~base_f(f_op, a, b);
      default: res = base_f(f_op, a, b);
    endcase
    return res;
  endfunction

  assign in_ready  = !r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign o         = r_o;
  assign w_fold    = base_f(r_op, r_acc, i0);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_o_nxt     = r_o;
    w_acc_load  = 1'b0;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    if (w_accept) begin
      if (r_state == S_IDLE) begin
        if (reduce && (op <= 3'd5)) begin
          w_latch    = 1'b1;
          w_acc_load = 1'b1;
          w_acc_nxt  = base_f(op, i0, i1);
          w_cnt_nxt  = '0;
          if (len == '0) begin
            // one-beat stream: result is simply the single op on (i0,i1)
            w_load  = 1'b1;
            w_o_nxt = logic_f(op, i0, i1, sel);
          end else begin
            w_state_nxt = S_ACC;
          end
        end else begin
          w_load  = 1'b1;
          w_o_nxt = logic_f(op, i0, i1, sel);
        end
      end else begin
        w_acc_load = 1'b1;
        w_acc_nxt  = w_fold;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == r_len - 1'b1) begin
          w_load      = 1'b1;
          w_o_nxt     = (r_op >= 3'd3) ? ~w_fold : w_fold;
          w_state_nxt = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_op        <= '0;
    end else begin
      if (w_load)            r_out_valid <= 1'b1;
      else if (out_ready)    r_out_valid <= 1'b0;
      if (w_load)            r_o         <= w_o_nxt;
      if (w_acc_load) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
      end
      if (w_latch) begin
        r_op  <= op;
        r_len <= len;
      end
    end
  end

`ifdef LOGIC_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_par <= 1'b0;
    else if (w_load) r_par <= ^w_o_nxt;
  end
  assign o_par = r_par;
`endif

endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed self-checking bench for logic_unit_acc: single ops, stall, reduce streams, async reset.
`timescale 1ns/1ps
module tb_logic_unit_acc;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       reduce;
  logic [3:0] len;
  logic [7:0] i0, i1, sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] o;
`ifdef LOGIC_PARITY_EN
  logic       o_par;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_acc #(.WIDTH(8), .BEATS_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .reduce(reduce), .len(len), .i0(i0), .i1(i1), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .o(o)
`ifdef LOGIC_PARITY_EN
    , .o_par(o_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // present one beat for one clock, then check just after the edge
  task automatic beat(input logic [2:0] b_op, input logic b_red, input logic [3:0] b_len,
                      input logic [7:0] b_i0, input logic [7:0] b_i1, input logic [7:0] b_sel);
    @(negedge clk);
    in_valid = 1'b1; op = b_op; reduce = b_red; len = b_len;
    i0 = b_i0; i1 = b_i1; sel = b_sel;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; op = '0; reduce = 1'b0; len = '0;
    i0 = '0; i1 = '0; sel = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_o", o, 8'h00);
    chk("rst_ready", in_ready, 1);
    @(negedge clk); reset_n = 1'b1;

    beat(3'd0, 1'b0, 4'd0, 8'hF0, 8'h3C, 8'h00);
    chk("and_valid", out_valid, 1);
    chk("and_o", o, 8'h30);
`ifdef LOGIC_PARITY_EN
    chk("and_par", o_par, 0);
`endif
    beat(3'd7, 1'b0, 4'd0, 8'hAA, 8'h55, 8'h0F);
    chk("mux_o", o, 8'hA5);
    beat(3'd6, 1'b0, 4'd0, 8'h0F, 8'h00, 8'h00);
    chk("not_o", o, 8'hF0);
`ifdef LOGIC_PARITY_EN
    chk("not_par", o_par, 0);
`endif

    // stall: consumer holds off for two cycles while a beat waits
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; reduce = 1'b0; i0 = 8'hFF; i1 = 8'h0F;
    #1 chk("stall_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("stall1_o", o, 8'hF0);
    chk("stall1_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("stall2_o", o, 8'hF0);
    chk("stall2_valid", out_valid, 1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("release_o", o, 8'h0F);
    chk("release_valid", out_valid, 1);
    idle_cycle();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold_o", o, 8'h0F);

    // reduce XOR over 3 beats; i1/op/reduce ignored after the first beat
    beat(3'd2, 1'b1, 4'd2, 8'h01, 8'h02, 8'h00);
    chk("rx1_valid", out_valid, 0);
    beat(3'd0, 1'b1, 4'd0, 8'h04, 8'hFF, 8'hFF);
    chk("rx2_valid", out_valid, 0);
    beat(3'd1, 1'b0, 4'd7, 8'h08, 8'hFF, 8'hFF);
    chk("rx3_valid", out_valid, 1);
    chk("rx3_o", o, 8'h0F);

    // reduce NOR over 2 beats, then single OR with no bubble
    beat(3'd4, 1'b1, 4'd1, 8'h01, 8'h02, 8'h00);
    chk("rn1_valid", out_valid, 0);
    beat(3'd2, 1'b0, 4'd0, 8'h04, 8'h00, 8'h00);
    chk("rn2_valid", out_valid, 1);
    chk("rn2_o", o, 8'hF8);
`ifdef LOGIC_PARITY_EN
    chk("rn2_par", o_par, 1);
`endif
    beat(3'd1, 1'b0, 4'd0, 8'h11, 8'h22, 8'h00);
    chk("or_b2b_valid", out_valid, 1);
    chk("or_b2b_o", o, 8'h33);

    // one-beat reduce NAND and reduce with MUX treated as single op
    beat(3'd3, 1'b1, 4'd0, 8'hF0, 8'h3C, 8'h00);
    chk("rnand_o", o, 8'hCF);
    beat(3'd7, 1'b1, 4'd3, 8'hF0, 8'h0F, 8'h3C);
    chk("rmux_o", o, 8'hCC);
    beat(3'd5, 1'b0, 4'd0, 8'h0F, 8'h3C, 8'h00);
    chk("xnor_o", o, 8'hCC);

    // reset in the middle of a reduce stream
    beat(3'd0, 1'b1, 4'd3, 8'hFF, 8'hFF, 8'h00);
    beat(3'd0, 1'b0, 4'd0, 8'h0F, 8'h00, 8'h00);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_o", o, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    idle_cycle();
    chk("postrst_noresult", out_valid, 0);
    beat(3'd2, 1'b0, 4'd0, 8'hFF, 8'h0F, 8'h00);
    chk("postrst_xor_valid", out_valid, 1);
    chk("postrst_xor_o", o, 8'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
